// File: rtl/wb_block_copy.sv
// Wishbone initiator that copies a block of 32-bit words, one read+write pair per word.
// Optional ack timeout/abort is compiled in with `define WB_BLOCK_COPY_TIMEOUT_EN.
module wb_block_copy #(
    parameter int LEN_W          = 12,
    parameter int RD_DATA_DLY    = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      adr_o,
    output logic [31:0]      dat_o,
    output logic             we_o,
    output logic             stb_o,
    output logic             cyc_o,
    input  logic [31:0]      dat_i,
    input  logic             ack_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_CAP = 3'd2,
        S_WR     = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t           r_state;
    logic [29:0]      r_src;
    logic [29:0]      r_dst;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_data;
    logic             w_timeout;
    logic             w_unused_lsbs;

    // Working addresses are kept as word indices, so byte-offset bits never matter.
    assign w_unused_lsbs = ^{src_addr[1:0], dst_addr[1:0]};
    assign dat_o         = r_data;

`ifdef WB_BLOCK_COPY_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = stb_o && !ack_i && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Count strobe cycles without an ack; any ack or idle strobe restarts the wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (stb_o && !ack_i && !w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Sticky abort flag, cleared only by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            err <= 1'b0;
        end else if (w_timeout) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end
`else
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Copy sequencer; every bus output is a register updated on the state transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_src   <= 30'd0;
            r_dst   <= 30'd0;
            r_cnt   <= '0;
            r_data  <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            adr_o   <= 32'd0;
            we_o    <= 1'b0;
            stb_o   <= 1'b0;
            cyc_o   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src <= src_addr[31:2];
                        r_dst <= dst_addr[31:2];
                        r_cnt <= len;
                        if (len == '0) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RD;
                            busy    <= 1'b1;
                            cyc_o   <= 1'b1;
                            stb_o   <= 1'b1;
                            we_o    <= 1'b0;
                            adr_o   <= {src_addr[31:2], 2'b00};
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (w_timeout) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                    end else if (stb_o && ack_i) begin
                        stb_o <= 1'b0;
                        if (RD_DATA_DLY == 0) begin
                            r_data  <= dat_i;
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD_CAP;
                        end
                    end else if (!stb_o) begin
                        // Re-strobe one cycle after the previous handshake.
                        stb_o <= 1'b1;
                        we_o  <= 1'b0;
                        adr_o <= {r_src, 2'b00};
                    end else begin
                        r_state <= S_RD;
                    end
                end
                S_RD_CAP: begin
                    r_data  <= dat_i;
                    r_state <= S_WR;
                    stb_o   <= 1'b1;
                    we_o    <= 1'b1;
                    adr_o   <= {r_dst, 2'b00};
                end
                S_WR: begin
                    if (w_timeout) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        we_o    <= 1'b0;
                    end else if (stb_o && ack_i) begin
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        r_src <= r_src + 30'd1;
                        r_dst <= r_dst + 30'd1;
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            cyc_o   <= 1'b0;
                        end else begin
                            r_state <= S_RD;
                        end
                    end else if (!stb_o) begin
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        adr_o <= {r_dst, 2'b00};
                    end else begin
                        r_state <= S_WR;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    cyc_o   <= 1'b0;
                    stb_o   <= 1'b0;
                    we_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_block_copy.sv
// Self-checking bench for wb_block_copy: single-cycle memory slave with registered read
// data, directed corner cases and randomized copies against an array-based reference.
module tb_wb_block_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [11:0] len;
    logic        busy, done, err;
    logic [31:0] adr_o, dat_o;
    logic        we_o, stb_o, cyc_o;
    logic [31:0] dat_i = 32'd0;
    logic        ack_i;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] rd_addrs[$];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          stb_seen = 0;
    logic        prev_hs = 1'b0;
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_dat = 32'd0;
    bit          ack_rand = 1'b0;
    bit          ack_force = 1'b1;
    bit          rnd_bit = 1'b1;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    wb_block_copy dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .err(err), .adr_o(adr_o), .dat_o(dat_o),
        .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    assign ack_i = stb_o & cyc_o & (ack_rand ? rnd_bit : ack_force);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory slave: ack = stb (optionally thinned), read data registered on the ack edge.
    always @(posedge clk) begin
        prev_hs <= stb_o & ack_i;
        if (pl_we) mem[pl_idx] <= pl_dat;
        if (stb_o && ack_i) begin
            if (we_o) begin
                mem[adr_o[11:2]] <= dat_o;
                wr_cnt <= wr_cnt + 1;
            end else begin
                dat_i  <= mem[adr_o[11:2]];
                rd_cnt <= rd_cnt + 1;
                rd_addrs.push_back(adr_o);
            end
        end
    end

    always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    // Per-cycle bus protocol observations.
    always @(negedge clk) begin
        if (mon_en) begin
            check("cyc_eq_busy", {31'd0, cyc_o}, {31'd0, busy});
            if (prev_hs) check("no_b2b_stb", {31'd0, stb_o}, 32'd0);
            if (stb_o) check("adr_align", {30'd0, adr_o[1:0]}, 32'd0);
            if (stb_o) stb_seen <= stb_seen + 1;
        end
    end

    task automatic poke(input int idx, input logic [31:0] val);
        pl_we  = 1'b1;
        pl_idx = idx[9:0];
        pl_dat = val;
        ref_mem[idx[9:0]] = val;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic compare_mem(input string tag);
        int nbad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
        check(tag, 32'(nbad), 32'd0);
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input bit poke_busy, input bit chk_lat);
        int   rd0, wr0;
        bit   got_done = 1'b0;
        logic pbusy = 1'b0;
        logic [31:0] ws, wd;
        // Reference: ascending word-by-word copy, as executed, over a 1024-word aliased memory.
        for (int i = 0; i < n; i++) begin
            ws = (s >> 2) + 32'(i);
            wd = (d >> 2) + 32'(i);
            ref_mem[wd[9:0]] = ref_mem[ws[9:0]];
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rd_addrs.delete();
        start = 1'b1; src_addr = s; dst_addr = d; len = n[11:0];
        @(negedge clk);
        start = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);
        if (n > 0) check("busy_rise", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 5000; k++) begin
            if (done) begin
                check("busy_at_done", {31'd0, busy}, 32'd0);
                check("busy_before_done", {31'd0, pbusy}, (n != 0) ? 32'd1 : 32'd0);
                if (chk_lat) check("done_latency", 32'(k), (n == 0) ? 32'd0 : 32'(4 * n - 1));
                got_done = 1'b1;
                break;
            end
            pbusy = busy;
            if (poke_busy && k == 5) begin
                start = 1'b1; src_addr = 32'h300; dst_addr = 32'h500; len = 12'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", {31'd0, got_done}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("done_single", {31'd0, done}, 32'd0);
        end
        check("read_count", 32'(rd_cnt - rd0), 32'(n));
        check("write_count", 32'(wr_cnt - wr0), 32'(n));
        compare_mem("mem_contents");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0;
        bit          found;
        logic [31:0] rs, rdst;
        rst = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = 12'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stb", {31'd0, stb_o}, 32'd0);
        check("rst_cyc", {31'd0, cyc_o}, 32'd0);
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_adr", adr_o, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < 1024; i++) poke(i, $urandom);
        for (int i = 0; i < 4; i++) poke(32'h40 + i, 32'(i + 1));

        // Basic 4-word copy with fixed latency.
        run_copy(32'h100, 32'h200, 4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) check("dst_word", mem[32'h80 + i], 32'(i + 1));

        // Zero-length: done only, never a strobe.
        s0 = stb_seen;
        run_copy(32'h180, 32'h280, 0, 1'b0, 1'b1);
        check("len0_no_stb", 32'(stb_seen - s0), 32'd0);

        // Start while busy is ignored.
        run_copy(32'h100, 32'h240, 4, 1'b1, 1'b1);

        // Reset while a write strobe is pending.
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h2C0; len = 12'd3;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (stb_o && we_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("wr_reached", {31'd0, found}, 32'd1);
        ack_force = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_stb", {31'd0, stb_o}, 32'd0);
        check("rst_mid_cyc", {31'd0, cyc_o}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        ack_force = 1'b1;
        @(negedge clk);
        check("rst_mid_no_late_done", {31'd0, done}, 32'd0);
        run_copy(32'h104, 32'h2C0, 3, 1'b0, 1'b1);

        // Source address wraps past 2^32.
        poke(32'h3FF, 32'hA5A5_0001);
        poke(0, 32'hA5A5_0002);
        run_copy(32'hFFFF_FFFC, 32'h080, 2, 1'b0, 1'b1);
        check("wrap_nreads", 32'(rd_addrs.size()), 32'd2);
        if (rd_addrs.size() >= 2) begin
            check("wrap_rd0", rd_addrs[0], 32'hFFFF_FFFC);
            check("wrap_rd1", rd_addrs[1], 32'h0000_0000);
        end
        check("wrap_dst0", mem[32'h20], 32'hA5A5_0001);
        check("wrap_dst1", mem[32'h21], 32'hA5A5_0002);

`ifdef WB_BLOCK_COPY_TIMEOUT_EN
        begin
            int nstb = 0;
            ack_force = 1'b0;
            start = 1'b1; src_addr = 32'h100; dst_addr = 32'h600; len = 12'd3;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 100; k++) begin
                if (!stb_o) break;
                nstb++;
                @(negedge clk);
            end
            check("to_stb_cycles", 32'(nstb), 32'd16);
            check("to_done", {31'd0, done}, 32'd1);
            check("to_err", {31'd0, err}, 32'd1);
            check("to_busy", {31'd0, busy}, 32'd0);
            check("to_cyc", {31'd0, cyc_o}, 32'd0);
            ack_force = 1'b1;
            @(negedge clk);
            check("to_err_sticky", {31'd0, err}, 32'd1);
            run_copy(32'h100, 32'h600, 1, 1'b0, 1'b1);
        end
`endif

        // Randomized copies with wait states, overlapping and wrapping ranges.
        ack_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            rs   = 32'($urandom_range(0, 127)) << 2;
            rdst = 32'($urandom_range(0, 127)) << 2;
            if ($urandom_range(0, 3) == 0) rs = rs - 32'h100;
            run_copy(rs, rdst, int'($urandom_range(0, 12)), 1'b0, 1'b0);
        end
        ack_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_block_copy.md
Name: wb_block_copy

Overview:
- Wishbone initiator (bus master) that copies a block of 32-bit words from a source word address to a destination word address.
- Drives the same single-cycle Wishbone slave memories used on the system bus.
- Started by a one-cycle command pulse from the CPU-side control logic.
- Reports busy/done; moves one word per read+write pair, no bursts.

Parameters:
- LEN_W, 12, width of the word-count field (max block = 2^LEN_W - 1 words)
- RD_DATA_DLY, 1, cycles after the read ack edge at which dat_i holds valid read data (0 or 1; 1 matches the registered-read memories)
- TIMEOUT_CYCLES, 16, cycles to wait for ack_i before aborting (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle command pulse; ignored while busy
- src_addr  in  32  source byte address, word aligned (bits [1:0] ignored)
- dst_addr  in  32  destination byte address, word aligned (bits [1:0] ignored)
- len  in  LEN_W  number of words to copy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transfer completes or aborts
- err  out  1  sticky abort flag; cleared by the next accepted start
- adr_o  out  32  Wishbone address, bits [1:0] always 0
- dat_o  out  32  Wishbone write data
- we_o  out  1  Wishbone write enable
- stb_o  out  1  Wishbone strobe
- cyc_o  out  1  Wishbone cycle, high while busy
- dat_i  in  32  Wishbone read data
- ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; all outputs 0; internal address, count and data registers 0. Reset mid-transfer drops stb_o/cyc_o on the next edge with no done pulse.
- IDLE: on start=1, latch src_addr, dst_addr and len into working registers, clear err, go to RD. If len=0: no bus cycle; done pulses on the next cycle; busy stays 0.
- RD: stb_o=1, we_o=0, adr_o=src. When ack_i=1 at an edge, go to RD_CAP if RD_DATA_DLY=1; if RD_DATA_DLY=0, latch dat_i into the data register and go to WR.
- RD_CAP: stb_o=0; latch dat_i into the data register; go to WR. The cycle is always exactly one cycle long.
- WR: stb_o=1, we_o=1, adr_o=dst, dat_o=data register. On ack_i=1: src+=4, dst+=4, count-=1. If the new count is 0, go to FIN; otherwise go to RD.
- FIN: done=1 for one cycle; busy, cyc_o and stb_o go to 0; return to IDLE.
- stb_o deasserts in the cycle after ack_i; there are no back-to-back strobes across state changes.
- Addresses wrap modulo 2^32 with no error.
- Overlapping src/dst ranges are copied in ascending order; the result is as-executed.
- start while busy is ignored, with no effect on any register.
- ack_i while stb_o=0 is ignored.

Optional Feature:
- Macro: WB_BLOCK_COPY_TIMEOUT_EN.
- Defined: a counter runs while stb_o=1 and resets on ack_i. On reaching TIMEOUT_CYCLES without ack_i, the block:
  - drops stb_o/cyc_o,
  - sets err=1,
  - goes to FIN (done pulses; the remaining count is discarded).
- Not defined: no counter; the block waits for ack_i indefinitely; err is tied to 0.

Test Plan:
- Memory model with combinational ack=stb and registered read data. Preload src words 0x100..0x10C = 1,2,3,4. start with src=0x100, dst=0x200, len=4 -> 0x200..0x20C = 1,2,3,4; exactly 4 reads and 4 writes; one done pulse; busy falls with done.
- start with len=0 -> no stb_o ever; done pulses 1 cycle after start; busy stays 0.
- Pulse start again while busy (src=0x300) -> ignored; the original transfer completes unchanged.
- Deassert rst while in WR -> next cycle stb_o=cyc_o=busy=0, no done; a fresh start then copies correctly.
- src=0xFFFFFFFC, len=2 -> second read is at 0x00000000 (wrap).
- With WB_BLOCK_COPY_TIMEOUT_EN defined, slave never acks -> after 16 cycles stb_o drops, err=1, done pulses; a subsequent start clears err.
